// File: rtl/duck_pkg.sv
// Shared constants and types for the duck sprite arbiter; no logic, no latency.
// Defaults describe the sprite ROM layout and may be overridden at the top.
package duck_pkg;

  localparam int         SPR_W           = 68;
  localparam int         SPR_H           = 64;
  localparam int         NUM_FRAMES      = 2;
  localparam logic [3:0] TRANSPARENT_IDX = 4'd0;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } duck_pos_t;

  // $clog2 that never yields a zero-width field
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/duck_sprite_arbiter_if.sv
// Pixel, duck-position and ROM signals between game/VGA side and the arbiter.
// Pure wiring; streaming, one pixel per cycle, no backpressure.
interface duck_sprite_arbiter_if
  import duck_pkg::*;
#(
  parameter int NUM_DUCKS = 4,
  parameter int ADDR_W    = 14,
  parameter int DUCK_W    = clog2_min1(NUM_DUCKS),
  parameter int FRAME_W   = clog2_min1(NUM_FRAMES)
);

  logic [9:0]             DrawX;
  logic [9:0]             DrawY;
  logic                   blank;
  logic                   frame_start;
  logic [NUM_DUCKS*10-1:0] duck_x;
  logic [NUM_DUCKS*10-1:0] duck_y;
  logic [NUM_DUCKS-1:0]   duck_en;
  logic [ADDR_W-1:0]      rom_address;
  logic [3:0]             rom_q;
  logic [3:0]             pix_index;
  logic                   pix_valid;
  logic [DUCK_W-1:0]      pix_duck;
  logic [FRAME_W-1:0]     anim_frame;

  modport master (
    output DrawX, DrawY, blank, frame_start, duck_x, duck_y, duck_en, rom_q,
    input  rom_address, pix_index, pix_valid, pix_duck, anim_frame
  );

  modport slave (
    input  DrawX, DrawY, blank, frame_start, duck_x, duck_y, duck_en, rom_q,
    output rom_address, pix_index, pix_valid, pix_duck, anim_frame
  );

endinterface

// File: rtl/duck_hit_test.sv
// Combinational bounding-box test of one duck against the current pixel.
// Zero latency; outputs are only meaningful while hit_o is high.
module duck_hit_test
  import duck_pkg::duck_pos_t;
#(
  parameter int SPR_W = 68,
  parameter int SPR_H = 64,
  parameter int RX_W  = 7,
  parameter int RY_W  = 6
) (
  input  logic [9:0]      draw_x_i,
  input  logic [9:0]      draw_y_i,
  input  duck_pos_t       pos_i,
  input  logic            en_i,
  output logic            hit_o,
  output logic [RX_W-1:0] rel_x_o,
  output logic [RY_W-1:0] rel_y_o
);

  logic [10:0] px, py, x_lo, y_lo, x_hi, y_hi;

  // 11-bit compares so a duck near the right/bottom edge cannot wrap its far bound
  assign px   = {1'b0, draw_x_i};
  assign py   = {1'b0, draw_y_i};
  assign x_lo = {1'b0, pos_i.x};
  assign y_lo = {1'b0, pos_i.y};
  assign x_hi = x_lo + 11'(SPR_W);
  assign y_hi = y_lo + 11'(SPR_H);

  assign hit_o = en_i && (px >= x_lo) && (px < x_hi) && (py >= y_lo) && (py < y_hi);

  assign rel_x_o = RX_W'(draw_x_i - pos_i.x);
  assign rel_y_o = RY_W'(draw_y_i - pos_i.y);

endmodule

// File: rtl/duck_sprite_arbiter.sv
// Picks the highest-priority duck under the pixel and fetches its sprite texel.
// Latency 2 cycles DrawX/DrawY -> pix_*; one pixel per cycle, never stalls.
module duck_sprite_arbiter #(
  parameter int NUM_DUCKS  = 4,
  parameter int SPR_W      = duck_pkg::SPR_W,
  parameter int SPR_H      = duck_pkg::SPR_H,
  parameter int NUM_FRAMES = duck_pkg::NUM_FRAMES,
  parameter int FRAME_DIV  = 8,
  parameter int ADDR_W     = 14
) (
  input logic                  vga_clk,
  input logic                  reset_n,
  duck_sprite_arbiter_if.slave bus
);

  import duck_pkg::duck_pos_t;
  import duck_pkg::TRANSPARENT_IDX;
  import duck_pkg::clog2_min1;

  localparam int DUCK_W      = clog2_min1(NUM_DUCKS);
  localparam int FRAME_W     = clog2_min1(NUM_FRAMES);
  localparam int DIV_W       = clog2_min1(FRAME_DIV);
  localparam int RX_W        = clog2_min1(SPR_W);
  localparam int RY_W        = clog2_min1(SPR_H);
  localparam int FRAME_WORDS = SPR_W * SPR_H;

  // Shadow copies of the game-side positions, refreshed only on frame_start
  duck_pos_t            pos_q [NUM_DUCKS];
  logic [NUM_DUCKS-1:0] en_q;

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [FRAME_W-1:0] anim_q, anim_d;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_DUCKS; i++) pos_q[i] <= '0;
      en_q <= '0;
    end else if (bus.frame_start) begin
      for (int i = 0; i < NUM_DUCKS; i++) begin
        pos_q[i].x <= bus.duck_x[10*i +: 10];
        pos_q[i].y <= bus.duck_y[10*i +: 10];
      end
      en_q <= bus.duck_en;
    end
  end

  always_comb begin
    div_cnt_d = div_cnt_q;
    anim_d    = anim_q;
    if (bus.frame_start) begin
      if (div_cnt_q == DIV_W'(FRAME_DIV - 1)) begin
        div_cnt_d = '0;
        anim_d    = (anim_q == FRAME_W'(NUM_FRAMES - 1)) ? '0 : anim_q + FRAME_W'(1);
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
      anim_q    <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      anim_q    <= anim_d;
    end
  end

  logic [NUM_DUCKS-1:0] hit_vec;
  logic [RX_W-1:0]      rel_x [NUM_DUCKS];
  logic [RY_W-1:0]      rel_y [NUM_DUCKS];

  for (genvar g = 0; g < NUM_DUCKS; g++) begin : g_hit
    duck_hit_test #(
      .SPR_W (SPR_W),
      .SPR_H (SPR_H),
      .RX_W  (RX_W),
      .RY_W  (RY_W)
    ) u_hit (
      .draw_x_i (bus.DrawX),
      .draw_y_i (bus.DrawY),
      .pos_i    (pos_q[g]),
      .en_i     (en_q[g]),
      .hit_o    (hit_vec[g]),
      .rel_x_o  (rel_x[g]),
      .rel_y_o  (rel_y[g])
    );
  end

  logic              any_hit;
  logic [DUCK_W-1:0] win_id;
  logic [RX_W-1:0]   win_rx;
  logic [RY_W-1:0]   win_ry;
  logic [ADDR_W-1:0] rom_addr_d;

  // Walk from lowest priority upward so the lowest hitting index is left standing
  always_comb begin
    any_hit = 1'b0;
    win_id  = '0;
    win_rx  = '0;
    win_ry  = '0;
    for (int i = NUM_DUCKS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        any_hit = 1'b1;
        win_id  = DUCK_W'(i);
        win_rx  = rel_x[i];
        win_ry  = rel_y[i];
      end
    end
    rom_addr_d = '0;
    if (any_hit) begin
      rom_addr_d = ADDR_W'(32'(anim_q) * 32'(FRAME_WORDS) + 32'(win_ry) * 32'(SPR_W) + 32'(win_rx));
    end
  end

  logic [ADDR_W-1:0] rom_addr_q;
  logic              hit_d1_q, blank_d1_q, hit_d2_q, blank_d2_q;
  logic [DUCK_W-1:0] duck_d1_q, duck_d2_q;
  logic [3:0]        pix_index_q;
  logic              pix_valid_q;
  logic [DUCK_W-1:0] pix_duck_q;

  // d2 registers align hit/blank/duck with rom_q, which the ROM returns a cycle later
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr_q  <= '0;
      hit_d1_q    <= 1'b0;
      blank_d1_q  <= 1'b0;
      duck_d1_q   <= '0;
      hit_d2_q    <= 1'b0;
      blank_d2_q  <= 1'b0;
      duck_d2_q   <= '0;
      pix_index_q <= '0;
      pix_valid_q <= 1'b0;
      pix_duck_q  <= '0;
    end else begin
      rom_addr_q  <= rom_addr_d;
      hit_d1_q    <= any_hit;
      blank_d1_q  <= bus.blank;
      duck_d1_q   <= win_id;
      hit_d2_q    <= hit_d1_q;
      blank_d2_q  <= blank_d1_q;
      duck_d2_q   <= duck_d1_q;
      pix_index_q <= bus.rom_q;
      pix_valid_q <= hit_d2_q && blank_d2_q && (bus.rom_q != TRANSPARENT_IDX);
      pix_duck_q  <= duck_d2_q;
    end
  end

  assign bus.rom_address = rom_addr_q;
  assign bus.pix_index   = pix_index_q;
  assign bus.pix_valid   = pix_valid_q;
  assign bus.pix_duck    = pix_duck_q;
  assign bus.anim_frame  = anim_q;

endmodule

// File: tb/tb_duck_sprite_arbiter.sv
// Directed bench for duck_sprite_arbiter with a behavioural sprite ROM (data = addr[3:0]).
module tb_duck_sprite_arbiter;

  logic vga_clk;
  logic reset_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  duck_sprite_arbiter_if #(.NUM_DUCKS(4), .ADDR_W(14)) bus ();

  duck_sprite_arbiter #(
    .NUM_DUCKS  (4),
    .SPR_W      (68),
    .SPR_H      (64),
    .NUM_FRAMES (2),
    .FRAME_DIV  (8),
    .ADDR_W     (14)
  ) dut (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    vga_clk = 1'b0;
    forever #5 vga_clk = ~vga_clk;
  end

  // Synchronous ROM model: one posedge from address to data
  always @(posedge vga_clk) bus.rom_q <= bus.rom_address[3:0];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int x, input int y, input bit blk);
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    bus.blank = blk;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic pulse();
    bus.frame_start = 1'b1;
    drive(0, 0, 1'b0);
    bus.frame_start = 1'b0;
  endtask

  task automatic set_duck(input int i, input int x, input int y);
    bus.duck_x[10*i +: 10] = 10'(x);
    bus.duck_y[10*i +: 10] = 10'(y);
  endtask

  function automatic int row50_addr(input int x);
    return (x >= 100 && x <= 167) ? x - 100 : 0;
  endfunction

  initial begin
    reset_n         = 1'b0;
    bus.DrawX       = '0;
    bus.DrawY       = '0;
    bus.blank       = 1'b0;
    bus.frame_start = 1'b0;
    bus.duck_x      = '0;
    bus.duck_y      = '0;
    bus.duck_en     = '0;
    repeat (3) @(posedge vga_clk);
    #1;
    chk("rst_addr",  32'(bus.rom_address), 0);
    chk("rst_index", 32'(bus.pix_index),   0);
    chk("rst_valid", 32'(bus.pix_valid),   0);
    chk("rst_duck",  32'(bus.pix_duck),    0);
    chk("rst_anim",  32'(bus.anim_frame),  0);
    @(negedge vga_clk);
    reset_n = 1'b1;
    @(posedge vga_clk);
    #1;

    // Single duck, row sweep across both edges
    set_duck(0, 100, 50);
    bus.duck_en = 4'b0001;
    pulse();                                  // pulse 1
    for (int x = 99; x <= 170; x++) begin
      drive(x, 50, 1'b1);
      chk("sweep_addr", 32'(bus.rom_address), 32'(row50_addr(x)));
      if (x >= 101) begin
        chk("sweep_index", 32'(bus.pix_index), 32'(row50_addr(x - 2) % 16));
        chk("sweep_valid", 32'(bus.pix_valid),
            32'((x - 2 >= 100 && x - 2 <= 167 && (row50_addr(x - 2) % 16) != 0) ? 1 : 0));
        chk("sweep_duck", 32'(bus.pix_duck), 0);
      end
    end

    // Overlap: lower index wins
    set_duck(0, 200, 100);
    set_duck(1, 230, 110);
    bus.duck_en = 4'b0011;
    pulse();                                  // pulse 2
    drive(240, 120, 1'b1);
    chk("ovl_addr0", 32'(bus.rom_address), 1400);
    drive(290, 150, 1'b1);
    chk("ovl_addr1", 32'(bus.rom_address), 2780);
    drive(0, 0, 1'b0);
    chk("ovl_duck0",  32'(bus.pix_duck),  0);
    chk("ovl_valid0", 32'(bus.pix_valid), 1);
    chk("ovl_index0", 32'(bus.pix_index), 8);
    drive(0, 0, 1'b0);
    chk("ovl_duck1",  32'(bus.pix_duck),  1);
    chk("ovl_index1", 32'(bus.pix_index), 12);

    // Mid-frame position write is ignored until frame_start
    set_duck(0, 300, 100);
    drive(240, 120, 1'b1);
    chk("shadow_hold", 32'(bus.rom_address), 1400);
    pulse();                                  // pulse 3
    drive(240, 120, 1'b1);
    chk("shadow_new_d1", 32'(bus.rom_address), 690);
    drive(310, 120, 1'b1);
    chk("shadow_new_d0", 32'(bus.rom_address), 1370);
    drive(0, 0, 1'b0);
    chk("shadow_duck1", 32'(bus.pix_duck), 1);
    drive(0, 0, 1'b0);
    chk("shadow_duck0", 32'(bus.pix_duck), 0);

    // Pixel coincident with frame_start still sees old shadows
    set_duck(0, 200, 100);
    bus.frame_start = 1'b1;                   // pulse 4
    drive(240, 120, 1'b1);
    bus.frame_start = 1'b0;
    chk("coinc_old", 32'(bus.rom_address), 690);
    drive(240, 120, 1'b1);
    chk("coinc_new", 32'(bus.rom_address), 1400);

    // Animation divider
    repeat (3) pulse();                       // pulses 5..7
    chk("anim_before", 32'(bus.anim_frame), 0);
    bus.frame_start = 1'b1;                   // pulse 8
    drive(240, 120, 1'b1);
    bus.frame_start = 1'b0;
    chk("anim_coinc_addr", 32'(bus.rom_address), 1400);
    chk("anim_step", 32'(bus.anim_frame), 1);
    drive(200, 100, 1'b1);
    chk("anim_origin", 32'(bus.rom_address), 4352);
    drive(240, 120, 1'b1);
    chk("anim_pix", 32'(bus.rom_address), 5752);
    repeat (7) pulse();                       // pulses 9..15
    chk("anim_hold", 32'(bus.anim_frame), 1);
    pulse();                                  // pulse 16
    chk("anim_wrap", 32'(bus.anim_frame), 0);
    drive(240, 120, 1'b1);
    chk("anim_wrap_addr", 32'(bus.rom_address), 1400);

    // Duck clipped at the bottom-right corner
    set_duck(2, 600, 440);
    bus.duck_en = 4'b0100;
    pulse();                                  // pulse 17
    drive(639, 479, 1'b1);
    chk("clip_addr", 32'(bus.rom_address), 2691);
    drive(599, 450, 1'b1);
    chk("clip_left", 32'(bus.rom_address), 0);
    drive(0, 0, 1'b0);
    chk("clip_duck",  32'(bus.pix_duck),  2);
    chk("clip_valid", 32'(bus.pix_valid), 1);
    drive(610, 450, 1'b0);
    chk("blank_addr", 32'(bus.rom_address), 690);
    drive(0, 0, 1'b0);
    drive(0, 0, 1'b0);
    chk("blank_valid", 32'(bus.pix_valid), 0);
    chk("blank_index", 32'(bus.pix_index), 2);

    // Reset in the middle of a drawn run
    drive(610, 450, 1'b1);
    drive(611, 450, 1'b1);
    drive(612, 450, 1'b1);
    chk("pre_rst_valid", 32'(bus.pix_valid), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_addr",  32'(bus.rom_address), 0);
    chk("mid_rst_valid", 32'(bus.pix_valid),   0);
    chk("mid_rst_index", 32'(bus.pix_index),   0);
    chk("mid_rst_duck",  32'(bus.pix_duck),    0);
    @(posedge vga_clk);
    @(negedge vga_clk);
    reset_n = 1'b1;
    drive(610, 450, 1'b1);
    chk("post_rst_addr", 32'(bus.rom_address), 0);
    drive(610, 450, 1'b1);
    drive(610, 450, 1'b1);
    chk("post_rst_valid", 32'(bus.pix_valid), 0);
    chk("post_rst_anim",  32'(bus.anim_frame), 0);
    pulse();
    drive(610, 450, 1'b1);
    chk("post_rst_hit", 32'(bus.rom_address), 690);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/duck_sprite_arbiter.md
# duck_sprite_arbiter

Shares one duck sprite ROM among NUM_DUCKS on-screen ducks on the VGA pixel path. For each pixel it picks the highest-priority duck whose bounding box covers (DrawX, DrawY) and forms that duck's ROM address, including the current animation frame. It returns the fetched palette index with a valid flag, two cycles later. It sits between the VGA controller/game logic and the shared sprite ROM → palette → colour output register.

## Interface
- NUM_DUCKS, 4: number of duck requesters; index 0 has highest priority.
- SPR_W, 68: sprite width in pixels.
- SPR_H, 64: sprite height in pixels.
- NUM_FRAMES, 2: animation frames stored back-to-back in the ROM.
- FRAME_DIV, 8: video frames per animation step.
- ADDR_W, 14: ROM address width; must satisfy NUM_FRAMES·SPR_W·SPR_H ≤ 2^ADDR_W.

- vga_clk  in  1  pixel clock; all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  1 = visible region.
- frame_start  in  1  one-cycle pulse at start of each video frame.
- duck_x  in  NUM_DUCKS·10  packed top-left x per duck; duck i at [10i+9:10i].
- duck_y  in  NUM_DUCKS·10  packed top-left y per duck.
- duck_en  in  NUM_DUCKS  per-duck draw enable.
- rom_address  out  ADDR_W  address to the shared sprite ROM.
- rom_q  in  4  ROM data; valid one posedge after rom_address.
- pix_index  out  4  palette index for the pixel.
- pix_valid  out  1  1 = duck pixel, opaque, visible.
- pix_duck  out  $clog2(NUM_DUCKS)  winning duck id.
- anim_frame  out  $clog2(NUM_FRAMES)  current animation frame.

## Operation
- Shadow registers: on frame_start, latch duck_x, duck_y and duck_en. All hit tests use only the shadow copies, so positions cannot tear mid-frame. Writes between pulses are ignored.
- Hit test per duck i: en_i && DrawX ≥ x_i && DrawX < x_i+SPR_W && DrawY ≥ y_i && DrawY < y_i+SPR_H.
  - Compares use 11-bit unsigned arithmetic, so x_i+SPR_W never overflows.
  - Ducks extending past 639/479 are clipped, because DrawX/DrawY never reach those coordinates.
- Arbitration: fixed priority, the lowest index among hitting ducks wins.
- Address: anim_frame·SPR_W·SPR_H + (DrawY−y_w)·SPR_W + (DrawX−x_w), truncated to ADDR_W. Products are sized so no intermediate wraps.
- No hit: rom_address = 0.
- Animation counter:
  - div_cnt counts frame_start pulses 0..FRAME_DIV−1.
  - When a pulse arrives with div_cnt = FRAME_DIV−1, div_cnt returns to 0 and anim_frame advances modulo NUM_FRAMES (NUM_FRAMES−1 → 0).
- Transparency: palette index 0 is transparent. pix_valid = hit_d2 && blank_d2 && rom_q ≠ 0.
- Simultaneous events:
  - frame_start in the same cycle as a pixel: the pixel uses the old shadows and old anim_frame. The new values apply from the next cycle.
- Reset (async assert, sync-released use):
  - Shadows, duck_en shadow, div_cnt, anim_frame, and all pipeline registers clear.
  - rom_address=0, pix_index=0, pix_valid=0, pix_duck=0, anim_frame=0.
  - Reset mid-frame drops in-flight pixels; no ducks draw until the first frame_start after release.

## Timing
- Stage 1 (posedge N): register rom_address, hit_d1, duck_d1 and blank_d1 from combinational hit/arbitration on the DrawX/DrawY of cycle N.
- ROM: synchronous on posedge vga_clk; rom_q holds the data for the stage-1 address after posedge N+1.
- Stage 2 (posedge N+2): register pix_index=rom_q, pix_valid and pix_duck.
- Total latency from DrawX/DrawY to pix_* is 2 cycles. The caller delays its background path by 2 cycles to match.
- Throughput: one pixel per cycle, no stalls, no backpressure.
- anim_frame updates on the posedge that samples frame_start.

## Structure
- Package duck_pkg holds:
  - SPR_W, SPR_H, NUM_FRAMES and TRANSPARENT_IDX (=0) defaults.
  - The duck_pos_t struct (x, y: 10 bits each).
- Sub-module duck_hit_test: one instance per duck. Inputs are DrawX, DrawY and the shadow position/enable. Outputs are hit plus rel_x/rel_y (7/6 bits). The parent does the priority encode, address multiply and pipeline.
- The ROM and palette are external and not instantiated here.

## Test plan
- Reset, then a single duck 0 at (100,50) enabled and one frame_start; sweep row 50 → rom_address = 0 at x=99 and x=168; 0..67 for x=100..167; pix_valid two cycles later only where the model ROM is nonzero.
- Ducks 0 at (200,100) and 1 at (230,110), both enabled; pixel (240,120) → pix_duck=0 and rom_address = 20·68+40 = 1400.
- Change duck_x mid-frame without frame_start → output unchanged. After the next frame_start → the new position is used.
- Issue 8 frame_start pulses (FRAME_DIV=8) → anim_frame goes 0→1 and the address at the duck origin becomes 4352. After 8 more pulses → anim_frame wraps to 0.
- Duck at (600,440) → visible region clipped at 639/479 with no address wrap. With blank=0 over the duck, pix_valid stays 0.
- Assert reset_n low mid-line while pix_valid=1 → all outputs 0 immediately. After release, no hits occur until frame_start.
